// File: rtl/dff_bank_ctrl.sv
// Sequencing controller for a bank of D flip-flops with active-low clear/preset.
// Applies one host operation at a time, then reads the bank back and reports mismatches.
module dff_bank_ctrl #(
   parameter int WIDTH = 8
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             REQ,
   input  logic [1:0]       OP,
   input  logic [WIDTH-1:0] DIN,
   output logic             BUSY,
   output logic             DONE,
   output logic             ERR,
   output logic [WIDTH-1:0] DOUT,
   output logic [WIDTH-1:0] D_OUT,
   output logic [WIDTH-1:0] CLR_N,
   output logic [WIDTH-1:0] PRE_N,
   input  logic [WIDTH-1:0] Q_IN,
   input  logic [WIDTH-1:0] QN_IN
);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_APPLY  = 2'd1,
      S_CHECK  = 2'd2,
      S_REPORT = 2'd3
   } state_t;

   typedef enum logic [1:0] {
      OP_LOAD   = 2'b00,
      OP_CLEAR  = 2'b01,
      OP_PRESET = 2'b10,
      OP_PINIT  = 2'b11
   } op_t;

   state_t           state_q, state_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic             err_q, err_d;
   logic [WIDTH-1:0] dout_q, dout_d;
   logic [WIDTH-1:0] exp_q, exp_d;
   logic [WIDTH-1:0] clr_n_q, clr_n_d;
   logic [WIDTH-1:0] pre_n_q, pre_n_d;

   always_comb begin
      // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latches).
      state_d = state_q;
      busy_d  = busy_q;
      done_d  = 1'b0;
      err_d   = err_q;
      dout_d  = dout_q;
      exp_d   = exp_q;
      clr_n_d = '1;
      pre_n_d = '1;

      unique case (state_q)
         S_IDLE: begin
            if (REQ) begin
               state_d = S_APPLY;
               busy_d  = 1'b1;
               unique case (op_t'(OP))
                  OP_LOAD:   exp_d = DIN;
                  OP_CLEAR: begin
                     exp_d   = '0;
                     clr_n_d = '0;
                  end
                  OP_PRESET: begin
                     exp_d   = '1;
                     pre_n_d = '0;
                  end
                  OP_PINIT: begin
                     // Complementary masks: a bit is either cleared or preset, never both.
                     exp_d   = DIN;
                     clr_n_d = DIN;
                     pre_n_d = ~DIN;
                  end
                  default: exp_d = exp_q;
               endcase
            end
         end
         S_APPLY: state_d = S_CHECK;
         S_CHECK: begin
            state_d = S_REPORT;
            dout_d  = Q_IN;
            done_d  = 1'b1;
            busy_d  = 1'b0;
            err_d   = (Q_IN != exp_q) || (QN_IN != ~Q_IN);
         end
         S_REPORT: state_d = S_IDLE;
         default:  state_d = S_IDLE;
      endcase
   end

   // Reset holds CLR_N low so the bank clears for as long as RST is asserted.
   always_ff @(posedge CLK) begin
      // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
      if (RST) begin
         state_q <= S_IDLE;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
         dout_q  <= '0;
         exp_q   <= '0;
         clr_n_q <= '0;
         pre_n_q <= '1;
      end else begin
         state_q <= state_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         err_q   <= err_d;
         dout_q  <= dout_d;
         exp_q   <= exp_d;
         clr_n_q <= clr_n_d;
         pre_n_q <= pre_n_d;
      end
   end

   // D mirrors the shadow value so the bank recaptures itself on idle edges.
   assign D_OUT = exp_q;
   assign BUSY  = busy_q;
   assign DONE  = done_q;
   assign ERR   = err_q;
   assign DOUT  = dout_q;
   assign CLR_N = clr_n_q;
   assign PRE_N = pre_n_q;

endmodule

// File: tb/tb_dff_bank_ctrl.sv
// Scoreboard bench for dff_bank_ctrl with a behavioural model of the flip-flop bank.
module tb_dff_bank_ctrl;

   localparam int W = 8;

   typedef struct packed {
      logic [W-1:0] dout;
      logic         err;
   } exp_t;

   logic         clk = 1'b0;
   logic         rst;
   logic         req;
   logic [1:0]   op;
   logic [W-1:0] din;
   logic         busy, done, err;
   logic [W-1:0] dout, d_out, clr_n, pre_n;
   logic [W-1:0] q_in, qn_in;
   logic [W-1:0] bank_q = 8'h5A;
   logic [W-1:0] fault_mask = '0;

   int   n_checks = 0;
   int   n_fail   = 0;
   int   cyc      = 0;
   int   done_cnt = 0;
   int   overlap  = 0;
   bit   prev_done = 1'b0;
   exp_t sb_q[$];
   int   acc_q[$];

   dff_bank_ctrl #(.WIDTH(W)) dut (
      .CLK(clk), .RST(rst), .REQ(req), .OP(op), .DIN(din),
      .BUSY(busy), .DONE(done), .ERR(err), .DOUT(dout),
      .D_OUT(d_out), .CLR_N(clr_n), .PRE_N(pre_n),
      .Q_IN(q_in), .QN_IN(qn_in)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Bank: synchronous active-low clear and preset, clear dominant.
   function automatic logic [W-1:0] bank_next(input logic [W-1:0] q, input logic [W-1:0] d,
                                              input logic [W-1:0] c, input logic [W-1:0] p);
      logic [W-1:0] n;
      n = q;
      for (int i = 0; i < W; i++) begin
         if (c[i] === 1'b0)      n[i] = 1'b0;
         else if (p[i] === 1'b0) n[i] = 1'b1;
         else                    n[i] = d[i];
      end
      return n;
   endfunction

   always @(posedge clk) bank_q <= bank_next(bank_q, d_out, clr_n, pre_n);
   assign q_in  = bank_q ^ fault_mask;
   assign qn_in = ~bank_q;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   always @(negedge clk) begin : monitor
      exp_t e;
      int   a;
      if ((~clr_n & ~pre_n) != '0) overlap++;
      if (done === 1'b1) begin
         done_cnt++;
         check("done_single_cycle", 32'(prev_done), 32'd0);
         if (sb_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_done: got DOUT=0x%0h ERR=%0b, expected no completion", dout, err);
         end else begin
            e = sb_q.pop_front();
            check("dout", 32'(dout), 32'(e.dout));
            check("err", 32'(err), 32'(e.err));
            if (acc_q.size() != 0) begin
               a = acc_q.pop_front();
               check("done_latency", 32'(cyc - a), 32'd2);
            end
         end
      end
      prev_done = (done === 1'b1);
   end

   task automatic wait_accept(output int acc, output bit ok);
      ok  = 1'b0;
      acc = 0;
      for (int i = 0; i < 12; i++) begin
         @(posedge clk);
         #1;
         if (busy === 1'b1) begin
            ok  = 1'b1;
            acc = cyc;
            break;
         end
      end
      check("accept_seen", 32'(ok), 32'd1);
   endtask

   task automatic do_op(input logic [1:0] o, input logic [W-1:0] d, input logic [W-1:0] exp_dout,
                        input bit exp_err, input bit inject, input bit abort);
      logic [W-1:0] ec, ep;
      exp_t         e;
      int           acc;
      bit           ok;
      case (o)
         2'b00:   begin ec = 8'hFF; ep = 8'hFF; end
         2'b01:   begin ec = 8'h00; ep = 8'hFF; end
         2'b10:   begin ec = 8'hFF; ep = 8'h00; end
         default: begin ec = d;     ep = ~d;    end
      endcase
      @(negedge clk);
      req = 1'b1;
      op  = o;
      din = d;
      if (!abort) begin
         e.dout = exp_dout;
         e.err  = exp_err;
         sb_q.push_back(e);
      end
      wait_accept(acc, ok);
      req = 1'b0;
      if (!abort) acc_q.push_back(acc);
      check("apply_clr_n", 32'(clr_n), 32'(ec));
      check("apply_pre_n", 32'(pre_n), 32'(ep));
      if (abort) begin
         rst = 1'b1;
         repeat (2) @(posedge clk);
         #1 rst = 1'b0;
      end else begin
         @(posedge clk);
         #1;
         if (inject) fault_mask = 8'h01;
         check("restore_clr_n", 32'(clr_n), 32'hFF);
         check("restore_pre_n", 32'(pre_n), 32'hFF);
         @(posedge clk);
         #1 fault_mask = '0;
         repeat (3) @(posedge clk);
      end
   endtask

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "timeout");
   end

   initial begin : stim
      int  a1, a2, bad;
      bit  ok;
      exp_t e;
      rst = 1'b1;
      req = 1'b0;
      op  = 2'b00;
      din = '0;

      // Reset held for two edges, then released.
      repeat (2) @(posedge clk);
      #1;
      check("rst_clr_n", 32'(clr_n), 32'h00);
      check("rst_pre_n", 32'(pre_n), 32'hFF);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_err", 32'(err), 32'd0);
      check("rst_dout", 32'(dout), 32'h00);
      check("rst_d_out", 32'(d_out), 32'h00);
      @(negedge clk) rst = 1'b0;
      @(posedge clk);
      #1;
      check("post_rst_clr_n", 32'(clr_n), 32'hFF);
      check("post_rst_bank", 32'(bank_q), 32'h00);

      // Load 0xA5 and confirm the bank keeps it while idle.
      do_op(2'b00, 8'hA5, 8'hA5, 1'b0, 1'b0, 1'b0);
      bad = 0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (bank_q !== 8'hA5) bad++;
      end
      check("load_hold_bad_cycles", 32'(bad), 32'd0);
      check("load_d_out", 32'(d_out), 32'hA5);

      // Pattern-init: clear where DIN=0, preset where DIN=1.
      do_op(2'b11, 8'h3C, 8'h3C, 1'b0, 1'b0, 1'b0);

      // Preset then clear with REQ held high the whole time.
      @(negedge clk);
      req = 1'b1;
      op  = 2'b10;
      din = 8'h00;
      e.dout = 8'hFF; e.err = 1'b0; sb_q.push_back(e);
      e.dout = 8'h00; e.err = 1'b0; sb_q.push_back(e);
      wait_accept(a1, ok);
      acc_q.push_back(a1);
      check("b2b_pre_n", 32'(pre_n), 32'h00);
      @(negedge clk) op = 2'b01;
      for (int i = 0; i < 8; i++) begin
         @(posedge clk);
         #1;
         if (busy === 1'b0) break;
      end
      wait_accept(a2, ok);
      acc_q.push_back(a2);
      req = 1'b0;
      check("b2b_accept_gap", 32'(a2 - a1), 32'd4);
      check("b2b_clr_n", 32'(clr_n), 32'h00);
      repeat (5) @(posedge clk);
      #1;
      check("b2b_idle_busy", 32'(busy), 32'd0);
      check("b2b_bank", 32'(bank_q), 32'h00);

      // Fault: bit 0 of Q flipped during CHECK; ERR must hold until the next completion.
      do_op(2'b00, 8'h0F, 8'h0E, 1'b1, 1'b1, 1'b0);
      repeat (3) @(posedge clk);
      #1;
      check("err_holds", 32'(err), 32'd1);
      check("fault_bank", 32'(bank_q), 32'h0F);
      do_op(2'b00, 8'h55, 8'h55, 1'b0, 1'b0, 1'b0);

      // Reset during APPLY of preset-all aborts the operation.
      do_op(2'b10, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1);
      repeat (4) @(posedge clk);
      #1;
      check("abort_busy", 32'(busy), 32'd0);
      check("abort_err", 32'(err), 32'd0);
      check("abort_bank", 32'(bank_q), 32'h00);
      check("abort_clr_n", 32'(clr_n), 32'hFF);

      check("done_count", 32'(done_cnt), 32'd6);
      check("scoreboard_empty", 32'(sb_q.size()), 32'd0);
      check("clr_pre_overlap_cycles", 32'(overlap), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
